// File: rtl/usb_audio_i2s_tx.sv
// Stereo FIFO feeding a 64-slot I2S transmitter with underrun reporting.
// Define I2S_TX_UNDERRUN_HOLD_EN to repeat the last sample on underrun.
module usb_audio_i2s_tx #(
  parameter int CLK_FREQ    = 60_000_000,
  parameter int SAMPLE_RATE = 48_000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in_L,
  input  logic [15:0] in_R,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        i2s_bclk,
  output logic        i2s_lrck,
  output logic        i2s_sd,
  output logic        underrun,
  output logic [7:0]  underrun_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [27:0] INC = 28'(128 * SAMPLE_RATE);
  localparam logic [27:0] MOD = 28'(CLK_FREQ);
  localparam logic [AW:0] FULL_LVL = FIFO_DEPTH[AW:0];
  localparam logic [AW:0] LVL_ONE = 1;
  localparam logic [AW-1:0] PTR_ONE = 1;

  logic [26:0]   acc;
  logic [27:0]   acc_next;
  logic          tick;
  logic          fall;
  logic [5:0]    bit_cnt;
  logic [5:0]    bit_nxt;
  logic [4:0]    slot;
  logic          wrap;
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [31:0]   head;
  logic [15:0]   sr_l;
  logic [15:0]   sr_r;
  logic [15:0]   chan;
  logic [3:0]    bit_idx;
  logic          sd_nxt;

  // Fractional divider: a toggle whenever the accumulator overflows CLK_FREQ
  always_comb begin
    acc_next = {1'b0, acc} + INC;
    tick     = acc_next >= MOD;
  end

  assign fall    = tick & i2s_bclk;
  assign bit_nxt = bit_cnt + 6'd1;
  assign slot    = bit_nxt[4:0];
  assign wrap    = fall & (bit_cnt == 6'd63);

  assign full     = level == FULL_LVL;
  assign empty    = level == '0;
  assign in_ready = ~rst & ~full;
  assign push     = in_valid & in_ready;
  assign pop      = wrap & ~empty;
  assign head     = mem[rd_ptr];

  assign chan    = bit_nxt[5] ? sr_r : sr_l;
  assign bit_idx = 4'(5'd16 - slot);

  always_comb begin
    sd_nxt = 1'b0;
    if (slot >= 5'd1 && slot <= 5'd16) begin
      sd_nxt = chan[bit_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      i2s_bclk <= 1'b0;
    end else if (tick) begin
      acc      <= 27'(acc_next - MOD);
      i2s_bclk <= ~i2s_bclk;
    end else begin
      acc      <= acc_next[26:0];
    end
  end

  // Serial outputs only move on BCLK falling toggles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt  <= '0;
      i2s_lrck <= 1'b0;
      i2s_sd   <= 1'b0;
    end else if (fall) begin
      bit_cnt  <= bit_nxt;
      i2s_lrck <= bit_nxt[5];
      i2s_sd   <= sd_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_L, in_R};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      unique case ({push, pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

  // Frame load: restore two's complement by flipping the offset-binary MSB
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_l <= '0;
      sr_r <= '0;
    end else if (pop) begin
      sr_l <= {~head[31], head[30:16]};
      sr_r <= {~head[15], head[14:0]};
    end else if (wrap) begin
`ifdef I2S_TX_UNDERRUN_HOLD_EN
      sr_l <= sr_l;
      sr_r <= sr_r;
`else
      sr_l <= '0;
      sr_r <= '0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      underrun <= wrap & empty;
      if (wrap && empty && underrun_cnt != 8'hFF) begin
        underrun_cnt <= underrun_cnt + 8'd1;
      end
    end
  end

endmodule
